// File: rtl/wr_arbiter.sv
// rtl/wr_arbiter.sv - round-robin burst arbiter sharing one FIFO write port
//
// Purpose: grants the FIFO write port to one of NREQ requesters at a time.
// A tenure lasts until the owner marks its last word, reaches MAX_BURST
// words, or drops its request. Each tenure is followed by one arbitration
// cycle. The search for the next owner starts just above the previous owner.
//
// Ports:
//   w_clk, wrst_n    write-domain clock, synchronous active-low reset
//   req/req_data     per-requester valid flag and data word (word i at [i*DSIZE +: DSIZE])
//   req_last         per-requester final-word-of-burst marker
//   f_full           FIFO full flag; blocks accepts, grant is held
//   gnt              registered one-hot grant, zero while arbitrating
//   ack              combinational per-requester accept strobe
//   w_en, wdata      combinational FIFO write enable and data
//   wr_count         saturating count of accepted words
//   stall_count      saturating count of cycles the owner was blocked by f_full
module wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DSIZE     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                  w_clk,
  input  logic                  wrst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*DSIZE-1:0] req_data,
  input  logic [NREQ-1:0]       req_last,
  input  logic                  f_full,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       ack,
  output logic                  w_en,
  output logic [DSIZE-1:0]      wdata,
  output logic [15:0]           wr_count,
  output logic [15:0]           stall_count
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [4:0]      beat_q, beat_d;
  logic [15:0]     wr_count_q, wr_count_d;
  logic [15:0]     stall_count_q, stall_count_d;

  logic [IW-1:0]   winner;
  logic            found;
  int              j;
  logic [IW-1:0]   jw;
  logic            own_req;
  logic            accept;
  logic            stall;
  logic            burst_done;
  logic [IW-1:0]   owner_next;

  // Round-robin search: first requester at or above rr_ptr, wrapping modulo NREQ.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    j      = 0;
    jw     = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(rr_ptr_q) + k;
      if (j >= NREQ) j = j - NREQ;
      jw = IW'(j);
      if (!found && req[jw]) begin
        found  = 1'b1;
        winner = jw;
      end
    end
  end

  assign own_req    = req[owner_q];
  // Reset gates accept so nothing is written while wrst_n is low.
  assign accept     = wrst_n && (state_q == BURST) && own_req && !f_full;
  assign stall      = (state_q == BURST) && own_req && f_full;
  assign owner_next = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
  // A dropped request ends the tenure without a write on that cycle.
  assign burst_done = (state_q == BURST) &&
                      (!own_req ||
                       (accept && (req_last[owner_q] || beat_q == 5'(MAX_BURST - 1))));

  // State register
  always_ff @(posedge w_clk) begin
    if (!wrst_n) begin
      state_q       <= IDLE;
      gnt_q         <= '0;
      owner_q       <= '0;
      rr_ptr_q      <= '0;
      beat_q        <= '0;
      wr_count_q    <= '0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      owner_q       <= owner_d;
      rr_ptr_q      <= rr_ptr_d;
      beat_q        <= beat_d;
      wr_count_q    <= wr_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    owner_d       = owner_q;
    rr_ptr_d      = rr_ptr_q;
    beat_d        = beat_q;
    wr_count_d    = (accept && wr_count_q != 16'hFFFF) ? wr_count_q + 16'd1 : wr_count_q;
    stall_count_d = (stall && stall_count_q != 16'hFFFF) ? stall_count_q + 16'd1 : stall_count_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = BURST;
          owner_d = winner;
          gnt_d   = NREQ'(1) << winner;
          beat_d  = '0;
        end
      end
      BURST: begin
        if (accept) beat_d = beat_q + 5'd1;
        if (burst_done) begin
          state_d  = IDLE;
          gnt_d    = '0;
          rr_ptr_d = owner_next;
        end
      end
    endcase
  end

  // Output logic
  always_comb begin
    ack   = '0;
    w_en  = accept;
    wdata = '0;
    if (accept) begin
      ack[owner_q] = 1'b1;
      wdata        = req_data[owner_q*DSIZE +: DSIZE];
    end
  end

  assign gnt         = gnt_q;
  assign wr_count    = wr_count_q;
  assign stall_count = stall_count_q;

endmodule

// File: doc/wr_arbiter.md
WR_ARBITER -- requirements
Module: wr_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of write requesters sharing the FIFO write port.
REQ-002 Parameter DSIZE, default 8, data word width.
REQ-003 Parameter MAX_BURST, default 4, maximum words granted to one requester per tenure (range 1..16).
REQ-004 Port w_clk  input  1  write-domain clock; all logic on rising edge.
REQ-005 Port wrst_n  input  1  synchronous, active-low reset.
REQ-006 Port req  input  NREQ  per-requester write request; bit i asserted means requester i holds a valid word.
REQ-007 Port req_data  input  NREQ*DSIZE  requester words; word i at bits [i*DSIZE +: DSIZE].
REQ-008 Port req_last  input  NREQ  bit i marks requester i's current word as the final word of its burst.
REQ-009 Port f_full  input  1  FIFO full flag, write domain.
REQ-010 Port gnt  output  NREQ  registered one-hot grant, all-zero when idle.
REQ-011 Port ack  output  NREQ  combinational; bit i marks requester i's word accepted this cycle.
REQ-012 Port w_en  output  1  combinational FIFO write enable.
REQ-013 Port wdata  output  DSIZE  combinational FIFO write data.
REQ-014 Port wr_count  output  16  registered count of accepted words, saturating.
REQ-015 Port stall_count  output  16  registered count of cycles with grant held, owner requesting and f_full high, saturating.

Function
REQ-016 FSM has two states: IDLE (gnt all-zero) and BURST (gnt one-hot, owner = grant index).
REQ-017 IDLE, any req bit high: winner = first requester with req high, searching upward from rr_ptr with modulo-NREQ wrap; next cycle gnt = onehot(winner), beat counter = 0, state = BURST.
REQ-018 IDLE, no req: state, gnt and rr_ptr unchanged.
REQ-019 Accept condition: state BURST, req[owner] high, f_full low.
REQ-020 On accept: w_en = 1, wdata = req_data word of owner, ack[owner] = 1. All other cycles: w_en = 0, ack = 0, wdata = 0.
REQ-021 f_full high in BURST: no accept; grant, beat counter and state held; stall_count increments when req[owner] is high.
REQ-022 Beat counter increments by 1 on each accept and is cleared on entry to BURST.
REQ-023 BURST ends (next cycle state = IDLE, gnt = 0, rr_ptr = owner+1 mod NREQ) on any one of:
  - an accept with req_last[owner] high;
  - an accept with beat counter = MAX_BURST-1;
  - req[owner] low (release without accept).
REQ-024 Each tenure is followed by exactly one IDLE arbitration cycle; words are never written on that cycle.
REQ-025 A requester that loses arbitration keeps req high; it is served within NREQ tenures (round-robin fairness, no starvation).
REQ-026 req and req_data of non-owners are ignored; at most one ack bit is ever high; ack and w_en are never high while f_full is high.
REQ-027 wr_count increments on each accept and stall_count per REQ-021; both hold at 16'hFFFF.

Reset
REQ-028 wrst_n low at a rising edge of w_clk: state = IDLE, gnt = 0, rr_ptr = 0, beat counter = 0, wr_count = 0, stall_count = 0.
REQ-029 While wrst_n is low, w_en = 0 and ack = 0 regardless of other inputs; reset in mid-burst abandons the tenure with no further writes.
REQ-030 First arbitration after reset release starts its search at requester 0.

Verification
REQ-031 After reset, req=4'b0100 and req_last high on the 2nd word with f_full=0 -> gnt=4'b0100 one cycle later; two w_en pulses carrying requester 2's words; gnt=0 the following cycle; rr_ptr=3; wr_count=2.
REQ-032 req=4'b1111 held, req_last=0, f_full=0 -> grant order 0,1,2,3,0; each tenure exactly 4 words (MAX_BURST) with one idle cycle between tenures; wr_count=16 after four tenures.
REQ-033 Owner 1 in BURST after 1 word, f_full held high 5 cycles then low -> no w_en for 5 cycles; stall_count=5; remaining 3 words written and tenure ends at 4 words.
REQ-034 Owner drops req after 2 words -> tenure ends with no accept on the drop cycle; next grant goes to the next requesting index above the owner.
REQ-035 wrst_n pulled low for one cycle mid-burst of owner 3 -> gnt=0, w_en=0, counters=0; first grant after release goes to requester 0 if requesting.
REQ-036 Forced wr_count=16'hFFFE, then 3 accepts -> wr_count saturates at 16'hFFFF.
